// File: rtl/updown_mon_pkg.sv
// ============================================================================
// Module : updown_mon_pkg
// Brief  : Shared types and constants for the up/down count-stream monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package updown_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACQ       = 2'd1,
        LOCK_UP   = 2'd2,
        LOCK_DOWN = 2'd3
    } mon_state_e;

    typedef enum logic [2:0] {
        RANGE = 3'd0,
        HOLD  = 3'd1,
        UP    = 3'd2,
        DOWN  = 3'd3,
        BAD   = 3'd4
    } step_class_e;

    localparam int                    ERRCNT_W   = 8;
    localparam logic [ERRCNT_W-1:0]   ERRCNT_SAT = ERRCNT_W'(255);

endpackage

`default_nettype wire

// File: rtl/updown_cnt_monitor_if.sv
// ============================================================================
// Module : updown_cnt_monitor_if
// Brief  : Sample strobe, bounds and status bundle of the count monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface updown_cnt_monitor_if #(
    parameter int W = 4
);
    import updown_mon_pkg::*;

    logic                VALID;
    logic [W-1:0]        IN;
    logic [W-1:0]        MIN;
    logic [W-1:0]        MAX;
    logic                LOCK;
    logic                DIR;
    logic                RUN;
    logic                WRAP;
    logic                ERR;
    logic [ERRCNT_W-1:0] ERR_CNT;

    // master drives the count stream, slave is the monitor
    modport master (
        output VALID, IN, MIN, MAX,
        input  LOCK, DIR, RUN, WRAP, ERR, ERR_CNT
    );

    modport slave (
        input  VALID, IN, MIN, MAX,
        output LOCK, DIR, RUN, WRAP, ERR, ERR_CNT
    );

endinterface

`default_nettype wire

// File: rtl/updown_step_classify.sv
// ============================================================================
// Module : updown_step_classify
// Brief  : Combinational classification of one sample against the previous.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module updown_step_classify
    import updown_mon_pkg::*;
#(
    parameter int W = 4
) (
    input  wire logic [W-1:0] i_prev,
    input  wire logic [W-1:0] i_in,
    input  wire logic [W-1:0] i_min,
    input  wire logic [W-1:0] i_max,
    input  wire logic         i_dir,
    output step_class_e       o_class
);

    logic [W-1:0] w_up_val;
    logic [W-1:0] w_dn_val;
    logic         w_range;
    logic         w_is_up;
    logic         w_is_dn;

    assign w_up_val = (i_prev == i_max) ? i_min : i_prev + W'(1);
    assign w_dn_val = (i_prev == i_min) ? i_max : i_prev - W'(1);
    // MIN>MAX makes every value fail one of these two compares
    assign w_range  = (i_in < i_min) || (i_in > i_max);
    assign w_is_up  = (i_in == w_up_val);
    assign w_is_dn  = (i_in == w_dn_val);

    always_comb begin
        o_class = BAD;
        if (w_range) begin
            o_class = RANGE;
        end else if (i_in == i_prev) begin
            o_class = HOLD;
        end else if (w_is_up && w_is_dn) begin
            // two-value span: both steps land on the same value, keep heading
            o_class = i_dir ? UP : DOWN;
        end else if (w_is_up) begin
            o_class = UP;
        end else if (w_is_dn) begin
            o_class = DOWN;
        end
    end

endmodule

`default_nettype wire

// File: rtl/updown_cnt_monitor.sv
// ============================================================================
// Module : updown_cnt_monitor
// Brief  : Recovers direction/run state of a bounded up/down count stream and
//          flags illegal steps, out-of-range values and wrap events.
//          UDMON_ERRCNT_EN builds the saturating error counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module updown_cnt_monitor
    import updown_mon_pkg::*;
#(
    parameter int W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    updown_cnt_monitor_if.slave   bus
);

    mon_state_e   state_q, state_d;
    logic [W-1:0] prev_q, prev_d;
    logic         lock_q, lock_d;
    logic         dir_q, dir_d;
    logic         run_q, run_d;
    logic         wrap_q, wrap_d;
    logic         err_q, err_d;
    step_class_e  w_class;

    updown_step_classify #(.W(W)) u_classify (
        .i_prev  (prev_q),
        .i_in    (bus.IN),
        .i_min   (bus.MIN),
        .i_max   (bus.MAX),
        .i_dir   (dir_q),
        .o_class (w_class)
    );

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        lock_d  = lock_q;
        dir_d   = dir_q;
        run_d   = run_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.VALID) begin
            if (w_class == RANGE) begin
                err_d   = 1'b1;
                state_d = IDLE;
                lock_d  = 1'b0;
            end else if (state_q == IDLE) begin
                prev_d  = bus.IN;
                state_d = ACQ;
                run_d   = 1'b0;
            end else begin
                case (w_class)
                    HOLD: begin
                        run_d = 1'b0;
                    end
                    UP: begin
                        prev_d  = bus.IN;
                        state_d = LOCK_UP;
                        lock_d  = 1'b1;
                        dir_d   = 1'b1;
                        run_d   = 1'b1;
                        wrap_d  = (prev_q == bus.MAX);
                    end
                    DOWN: begin
                        prev_d  = bus.IN;
                        state_d = LOCK_DOWN;
                        lock_d  = 1'b1;
                        dir_d   = 1'b0;
                        run_d   = 1'b1;
                        wrap_d  = (prev_q == bus.MIN);
                    end
                    default: begin
                        // a bad step while still acquiring just re-seeds
                        prev_d = bus.IN;
                        run_d  = 1'b0;
                        if (state_q != ACQ) begin
                            err_d   = 1'b1;
                            state_d = ACQ;
                            lock_d  = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            lock_q  <= 1'b0;
            dir_q   <= 1'b0;
            run_q   <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            lock_q  <= lock_d;
            dir_q   <= dir_d;
            run_q   <= run_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

`ifdef UDMON_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != ERRCNT_SAT)) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.ERR_CNT = err_cnt_q;
`else
    assign bus.ERR_CNT = '0;
`endif

    assign bus.LOCK = lock_q;
    assign bus.DIR  = dir_q;
    assign bus.RUN  = run_q;
    assign bus.WRAP = wrap_q;
    assign bus.ERR  = err_q;

endmodule

`default_nettype wire

// File: doc/updown_cnt_monitor.md
# updown_cnt_monitor

Receive-side companion to the team's bounded up/down counters: observes a W-bit count stream sampled on a strobe and, given the same MIN/MAX bounds, recovers direction (up/down) and run/hold state. Flags illegal steps, out-of-range values and wrap-around events. Sits downstream of a counter, or across a board link, as a checker and monitor.

## Interface
- W, default 4: count width.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- VALID  input  1  IN is sampled on the clk edge where VALID=1.
- IN  input  W  observed count value.
- MIN  input  W  lower bound, inclusive.
- MAX  input  W  upper bound, inclusive.
- LOCK  output  1  direction acquired.
- DIR  output  1  recovered direction: 1=up, 0=down. Meaningful when LOCK=1.
- RUN  output  1  1 = last accepted sample stepped; 0 = held.
- WRAP  output  1  one-cycle pulse on a MAX→MIN (up) or MIN→MAX (down) step.
- ERR  output  1  one-cycle pulse on an illegal sample.
- ERR_CNT  output  8  saturating error count.

## Operation
- Internal PREV (W bits) holds the last accepted sample.
- Sample classification against PREV, using the MIN/MAX values present on that cycle:
  - RANGE: IN<MIN or IN>MAX. When MIN>MAX, every sample is RANGE.
  - HOLD: IN==PREV.
  - UP: IN == (PREV==MAX ? MIN : PREV+1).
  - DOWN: IN == (PREV==MIN ? MAX : PREV-1).
  - BAD: none of the above.
- Precedence: RANGE > HOLD > UP/DOWN > BAD.
- When MAX-MIN==1, UP and DOWN coincide. The block treats the step as a step in the current DIR.
- When MIN==MAX, every in-range sample is HOLD.
- States:
  - IDLE: VALID with in-range IN → capture PREV, go to ACQ.
  - ACQ:
    - HOLD → stay, RUN=0.
    - UP → LOCK_UP.
    - DOWN → LOCK_DOWN.
    - BAD → stay, PREV=IN, no ERR.
  - LOCK_UP / LOCK_DOWN:
    - UP or DOWN → corresponding LOCK state, RUN=1. A direction reversal is legal.
    - HOLD → stay, RUN=0.
    - BAD → ERR, go to ACQ, PREV=IN.
  - RANGE in any state → ERR, go to IDLE. PREV is not updated.
- LOCK=1 exactly in LOCK_UP and LOCK_DOWN. DIR=1 in LOCK_UP, DIR=0 in LOCK_DOWN. DIR holds its value in ACQ and IDLE.
- WRAP asserts on an accepted UP step from MAX or DOWN step from MIN, in ACQ or either LOCK state.
- ERR_CNT increments on each ERR and saturates at 255.

## Timing
- All outputs are registered and update on the clk edge that samples VALID=1. They are visible one cycle after the strobe.
- When VALID=0: state, PREV, LOCK, DIR and RUN hold; WRAP and ERR deassert.
- WRAP and ERR are single-cycle pulses. Back-to-back strobes produce back-to-back pulses.
- rst=0 forces, immediately and independent of clk: state=IDLE, PREV=0, LOCK=0, DIR=0, RUN=0, WRAP=0, ERR=0, ERR_CNT=0.
- Release of rst is synchronised externally. The first edge after release may sample.

## Configuration
- UDMON_ERRCNT_EN defined: the 8-bit saturating ERR_CNT register is built.
- UDMON_ERRCNT_EN undefined: ERR_CNT is tied to 0 and no counter logic is generated. ERR pulses are unaffected.

## Structure
- Shared package updown_mon_pkg contains:
  - state enum IDLE/ACQ/LOCK_UP/LOCK_DOWN;
  - classification enum RANGE/HOLD/UP/DOWN/BAD;
  - ERR_CNT width constant (8) and saturation value (255).
- One combinational sub-module, updown_step_classify (inputs PREV, IN, MIN, MAX, DIR; output class), holds all arithmetic.
- The top module holds the FSM and registers.

## Test plan
All scenarios use W=4, MIN=3, MAX=9, one strobe per sample.
- Reset, then samples 3,4,5 → after the 4 strobe: LOCK=1, DIR=1, RUN=1; ERR never pulses.
- Locked up, samples 8,9,3 → WRAP pulses exactly on the cycle after the 3 strobe; LOCK=1, DIR=1, ERR=0.
- Samples 5,4,3,9 → DIR=0 after the 4 strobe; WRAP pulses after the 9 strobe; then sample 6 → ERR, ERR_CNT=1, LOCK=0.
- Locked at 6, samples 6,6 → RUN=0 and LOCK remains 1; then sample 12 → ERR, state IDLE, LOCK=0.
- MIN=MAX=5, samples 5,5 → RUN=0, LOCK=0, no ERR.
- ERR_CNT saturation and reset:
  - 300 RANGE samples → ERR_CNT=255 with the macro defined, 0 without.
  - Drive rst low mid-stream, asynchronous to clk → all outputs 0 before the next clk edge.
